// File: rtl/mac_sequencer_pkg.sv
// mac_sequencer_pkg: shared SAP-1 MAC opcode encodings
package mac_sequencer_pkg;
  localparam logic [3:0] MAC_REGA  = 4'h1;
  localparam logic [3:0] MAC_REGB  = 4'h2;
  localparam logic [3:0] MAC_MULT  = 4'h3;
  localparam logic [3:0] MAC_ACC   = 4'h4;
  localparam logic [3:0] MAC_MSW   = 4'h5;
  localparam logic [3:0] MAC_LSW   = 4'h6;
  localparam logic [3:0] MAC_RESET = 4'h7;
  localparam logic [3:0] MAC_NOP   = 4'hF;
endpackage

// File: rtl/mac_sequencer.sv
// mac_sequencer: dot-product initiator for the MAC; MAC_SEQ_SATURATE_EN clamps overflowed results to all ones
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    a_reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    res_overflow,
  output logic [3:0]              mac_opcode,
  output logic [DATA_WIDTH-1:0]   mac_data_in,
  input  logic [DATA_WIDTH-1:0]   mac_data_out,
  input  logic                    mac_acc_overflow,
  output logic                    busy
);
  localparam logic [3:0] IDLE = 4'd0, CLR = 4'd1, FETCH = 4'd2, LOAD_A = 4'd3, LOAD_B = 4'd4,
                         MULT = 4'd5, ACC = 4'd6, RD_MSW = 4'd7, RD_LSW = 4'd8, CAPT = 4'd9,
                         DONE = 4'd10;
  logic [3:0]            state, state_n;
  logic [LEN_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] b_q;
  always_ff @(posedge clk or negedge a_reset_n)
    if (!a_reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = CLR;
      CLR:     state_n = count == '0 ? RD_MSW : FETCH;
      FETCH:   if (in_valid) state_n = LOAD_A;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = MULT;
      MULT:    state_n = ACC;
      ACC:     state_n = count == LEN_WIDTH'(1) ? RD_MSW : FETCH;
      RD_MSW:  state_n = RD_LSW;
      RD_LSW:  state_n = CAPT;
      CAPT:    state_n = DONE;
      DONE:    if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // a goes straight into mac_data_in so LOAD_A drives it from a register; b waits in b_q
  always_ff @(posedge clk or negedge a_reset_n)
    if (!a_reset_n) begin
      count        <= '0;
      b_q          <= '0;
      mac_data_in  <= '0;
      res_data     <= '0;
      res_overflow <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) count <= cmd_len;
      if (state == ACC) count <= count - LEN_WIDTH'(1);
      if (state == FETCH && in_valid) begin
        mac_data_in <= in_a;
        b_q         <= in_b;
      end
      if (state == LOAD_A) mac_data_in <= b_q;
      if (state == RD_LSW) res_data[2*DATA_WIDTH-1:DATA_WIDTH] <= mac_data_out;
      if (state == CAPT) begin
        res_overflow <= mac_acc_overflow;
`ifdef MAC_SEQ_SATURATE_EN
        res_data <= mac_acc_overflow ? '1 : {res_data[2*DATA_WIDTH-1:DATA_WIDTH], mac_data_out};
`else
        res_data[DATA_WIDTH-1:0] <= mac_data_out;
`endif
      end
    end
  always_comb begin
    cmd_ready  = state == IDLE;
    in_ready   = state == FETCH;
    res_valid  = state == DONE;
    busy       = state != IDLE;
    mac_opcode = state == CLR    ? MAC_RESET :
                 state == LOAD_A ? MAC_REGA  :
                 state == LOAD_B ? MAC_REGB  :
                 state == MULT   ? MAC_MULT  :
                 state == ACC    ? MAC_ACC   :
                 state == RD_MSW ? MAC_MSW   :
                 state == RD_LSW ? MAC_LSW   : MAC_NOP;
  end
endmodule
